// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with write-through bypass and busy scoreboard
module regfile_scoreboard #(
  parameter int XLEN       = 64,
  parameter int NREGS      = 32,
  parameter int INIT_INDEX = 1,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    Rs1,
  input  logic [AW-1:0]    Rs2,
  output logic [XLEN-1:0]  ReadData1,
  output logic [XLEN-1:0]  ReadData2,
  input  logic [AW-1:0]    Rd,
  input  logic [XLEN-1:0]  WriteData,
  input  logic             RegWrite,
  input  logic             IssueValid,
  input  logic [AW-1:0]    IssueRd,
  input  logic             IssueWrites,
  input  logic             IssueUsesRs1,
  input  logic             IssueUsesRs2,
  input  logic             Flush,
  output logic             Stall,
  output logic [NREGS-1:0] BusyVec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] effbusy;
  logic             wr_en;
  logic             fire;
  logic             hazard;

  // Writes to register 0 are dropped everywhere (array, bypass, scoreboard).
  assign wr_en = RegWrite & (Rd != '0);

  // Register array: index-valued or zero reset, register 0 never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (INIT_INDEX != 0) ? XLEN'(i) : '0;
      end
    end else if (wr_en) begin
      regs[Rd] <= WriteData;
    end
  end

  // Read ports: zero register, then same-cycle writeback bypass, then array.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (!reset) begin
      if (Rs1 == '0)                  ReadData1 = '0;
      else if (wr_en && (Rd == Rs1))  ReadData1 = WriteData;
      else                            ReadData1 = regs[Rs1];
      if (Rs2 == '0)                  ReadData2 = '0;
      else if (wr_en && (Rd == Rs2))  ReadData2 = WriteData;
      else                            ReadData2 = regs[Rs2];
    end
  end

  // Effective busy: a register whose writeback lands this cycle is already free.
  always_comb begin
    effbusy = '0;
    for (int i = 1; i < NREGS; i++) begin
      effbusy[i] = busy[i] & ~(wr_en & (Rd == AW'(i)));
    end
  end

  // RAW on either source plus WAW on the destination; a flush squashes the stall.
  assign hazard = (IssueUsesRs1 & effbusy[Rs1]) |
                  (IssueUsesRs2 & effbusy[Rs2]) |
                  (IssueWrites  & effbusy[IssueRd]);
  assign Stall  = ~reset & IssueValid & ~Flush & hazard;
  assign fire   = IssueValid & ~Stall & ~Flush & IssueWrites & (IssueRd != '0);

  // Scoreboard: flush clears all, else writeback clears then issue sets (set wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (Flush) begin
      busy <= '0;
    end else begin
      logic [NREGS-1:0] next_busy;
      next_busy = busy;
      if (wr_en) next_busy[Rd]      = 1'b0;
      if (fire)  next_busy[IssueRd] = 1'b1;
      busy <= next_busy;
    end
  end

  assign BusyVec = busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic             clk;
  logic             reset;
  logic [AW-1:0]    Rs1, Rs2, Rd, IssueRd;
  logic [XLEN-1:0]  ReadData1, ReadData2, WriteData;
  logic             RegWrite, IssueValid, IssueWrites, IssueUsesRs1, IssueUsesRs2, Flush;
  logic             Stall;
  logic [NREGS-1:0] BusyVec;

  int errors = 0;
  int checks = 0;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .INIT_INDEX(1)) dut (
    .clk(clk), .reset(reset),
    .Rs1(Rs1), .Rs2(Rs2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Rd(Rd), .WriteData(WriteData), .RegWrite(RegWrite),
    .IssueValid(IssueValid), .IssueRd(IssueRd), .IssueWrites(IssueWrites),
    .IssueUsesRs1(IssueUsesRs1), .IssueUsesRs2(IssueUsesRs2),
    .Flush(Flush), .Stall(Stall), .BusyVec(BusyVec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 0; Rd = '0; WriteData = '0;
    IssueValid = 0; IssueRd = '0; IssueWrites = 0;
    IssueUsesRs1 = 0; IssueUsesRs2 = 0; Flush = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle(); Rs1 = 5'd5; Rs2 = 5'd31;
    tick(); tick();
    checks++; if (ReadData1 !== 64'h0) begin errors++; $display("FAIL rst_rd1_held got=%0h exp=0", ReadData1); end
    checks++; if (BusyVec !== 32'h0) begin errors++; $display("FAIL rst_busy_held got=%0h exp=0", BusyVec); end
    reset = 0; #1;
    checks++; if (ReadData1 !== 64'd5) begin errors++; $display("FAIL rst_rd1 got=%0h exp=5", ReadData1); end
    checks++; if (ReadData2 !== 64'd31) begin errors++; $display("FAIL rst_rd2 got=%0h exp=1f", ReadData2); end
    checks++; if (BusyVec !== 32'h0) begin errors++; $display("FAIL rst_busy got=%0h exp=0", BusyVec); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0b exp=0", Stall); end
  endtask

  task automatic test_write_bypass();
    idle(); RegWrite = 1; Rd = 5'd7; WriteData = 64'hDEAD; Rs1 = 5'd7; Rs2 = 5'd8; #1;
    checks++; if (ReadData1 !== 64'hDEAD) begin errors++; $display("FAIL bypass_rd1 got=%0h exp=dead", ReadData1); end
    checks++; if (ReadData2 !== 64'd8) begin errors++; $display("FAIL bypass_rd2 got=%0h exp=8", ReadData2); end
    tick(); idle(); #1;
    checks++; if (ReadData1 !== 64'hDEAD) begin errors++; $display("FAIL array_rd1 got=%0h exp=dead", ReadData1); end
    RegWrite = 1; Rd = 5'd0; WriteData = 64'h55; Rs1 = 5'd0; Rs2 = 5'd0; #1;
    checks++; if (ReadData1 !== 64'h0) begin errors++; $display("FAIL r0_bypass got=%0h exp=0", ReadData1); end
    tick(); idle(); #1;
    checks++; if (ReadData2 !== 64'h0) begin errors++; $display("FAIL r0_array got=%0h exp=0", ReadData2); end
    checks++; if (BusyVec !== 32'h0) begin errors++; $display("FAIL r0_busy got=%0h exp=0", BusyVec); end
  endtask

  task automatic test_raw_stall();
    idle(); IssueValid = 1; IssueRd = 5'd3; IssueWrites = 1; #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL raw_issue_stall got=%0b exp=0", Stall); end
    tick(); idle(); #1;
    checks++; if (BusyVec !== 32'h8) begin errors++; $display("FAIL raw_busy_set got=%0h exp=8", BusyVec); end
    IssueValid = 1; Rs1 = 5'd3; IssueUsesRs1 = 1; #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL raw_stall got=%0b exp=1", Stall); end
    RegWrite = 1; Rd = 5'd3; WriteData = 64'h99; #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL raw_wb_stall got=%0b exp=0", Stall); end
    checks++; if (ReadData1 !== 64'h99) begin errors++; $display("FAIL raw_wb_rd1 got=%0h exp=99", ReadData1); end
    tick(); idle(); #1;
    checks++; if (BusyVec !== 32'h0) begin errors++; $display("FAIL raw_busy_clr got=%0h exp=0", BusyVec); end
  endtask

  task automatic test_waw();
    idle(); IssueValid = 1; IssueRd = 5'd4; IssueWrites = 1;
    tick();
    #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL waw_stall got=%0b exp=1", Stall); end
    tick();
    checks++; if (BusyVec !== 32'h10) begin errors++; $display("FAIL waw_hold got=%0h exp=10", BusyVec); end
    RegWrite = 1; Rd = 5'd4; WriteData = 64'h44; #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL waw_wb_stall got=%0b exp=0", Stall); end
    tick(); idle(); Rs1 = 5'd4; #1;
    checks++; if (BusyVec !== 32'h10) begin errors++; $display("FAIL waw_set_wins got=%0h exp=10", BusyVec); end
    checks++; if (ReadData1 !== 64'h44) begin errors++; $display("FAIL waw_data got=%0h exp=44", ReadData1); end
  endtask

  task automatic test_flush();
    idle(); IssueValid = 1; IssueRd = 5'd3; IssueWrites = 1;
    tick(); idle(); #1;
    checks++; if (BusyVec !== 32'h18) begin errors++; $display("FAIL flush_pre got=%0h exp=18", BusyVec); end
    Flush = 1; IssueValid = 1; IssueRd = 5'd5; IssueWrites = 1; IssueUsesRs1 = 1; Rs1 = 5'd3; #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%0b exp=0", Stall); end
    tick(); idle(); #1;
    checks++; if (BusyVec !== 32'h0) begin errors++; $display("FAIL flush_busy got=%0h exp=0", BusyVec); end
    RegWrite = 1; Rd = 5'd3; WriteData = 64'h333;
    tick(); idle(); Rs1 = 5'd3; #1;
    checks++; if (ReadData1 !== 64'h333) begin errors++; $display("FAIL flush_late_wb got=%0h exp=333", ReadData1); end
    checks++; if (BusyVec !== 32'h0) begin errors++; $display("FAIL flush_late_busy got=%0h exp=0", BusyVec); end
  endtask

  task automatic test_misc();
    idle(); IssueValid = 1; IssueRd = 5'd6; IssueWrites = 1;
    tick(); idle();
    IssueValid = 1; Rs1 = 5'd1; IssueUsesRs1 = 1; Rs2 = 5'd6; IssueUsesRs2 = 0; #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rs2_unused got=%0b exp=0", Stall); end
    IssueUsesRs2 = 1; #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL rs2_used got=%0b exp=1", Stall); end
    idle(); IssueValid = 1; IssueWrites = 1; IssueRd = 5'd0; #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rd0_stall got=%0b exp=0", Stall); end
    tick(); idle(); #1;
    checks++; if (BusyVec !== 32'h40) begin errors++; $display("FAIL rd0_busy got=%0h exp=40", BusyVec); end
  endtask

  task automatic test_reset_mid();
    idle(); Rs1 = 5'd7; Rs2 = 5'd3; IssueValid = 1; IssueUsesRs1 = 1; Rs1 = 5'd6;
    #1;
    reset = 1; #1;
    checks++; if (ReadData2 !== 64'h0) begin errors++; $display("FAIL mid_rst_rd2 got=%0h exp=0", ReadData2); end
    checks++; if (BusyVec !== 32'h0) begin errors++; $display("FAIL mid_rst_busy got=%0h exp=0", BusyVec); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got=%0b exp=0", Stall); end
    idle(); Rs1 = 5'd7; tick();
    reset = 0; #1;
    checks++; if (ReadData1 !== 64'd7) begin errors++; $display("FAIL mid_rst_r7 got=%0h exp=7", ReadData1); end
    checks++; if (ReadData2 !== 64'd3) begin errors++; $display("FAIL mid_rst_r3 got=%0h exp=3", ReadData2); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_raw_stall();
    test_waw();
    test_flush();
    test_misc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the 5-stage pipeline: NREGS entries of XLEN bits, two combinational read ports, and one writeback port with write-through bypass.
- Carries a per-register busy scoreboard. Decode marks a destination busy when it issues; writeback clears it.
- The block drives Stall when an issuing instruction would read, or overwrite, a register that still has a write pending.
- Register 0 is hardwired to zero.

Parameters:
XLEN, 64, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2)
AW, $clog2(NREGS), register index width (derived, not overridden)
INIT_INDEX, 1, 1: reset value of register i is i (register 0 stays 0); 0: all registers reset to 0

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
Rs1  input  AW  read port 1 index
Rs2  input  AW  read port 2 index
ReadData1  output  XLEN  read port 1 data (combinational)
ReadData2  output  XLEN  read port 2 data (combinational)
Rd  input  AW  writeback destination index
WriteData  input  XLEN  writeback data
RegWrite  input  1  writeback enable
IssueValid  input  1  decode stage presents an instruction
IssueRd  input  AW  destination of the issuing instruction
IssueWrites  input  1  issuing instruction writes IssueRd
IssueUsesRs1  input  1  issuing instruction reads Rs1
IssueUsesRs2  input  1  issuing instruction reads Rs2
Flush  input  1  clear all busy bits (pipeline squash)
Stall  output  1  hazard; decode must hold (combinational)
BusyVec  output  NREGS  current scoreboard bits, bit i = register i pending

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - Registers are set to i if INIT_INDEX=1, otherwise 0.
  - All busy bits are cleared.
  - While reset is high, ReadData1 and ReadData2 read 0, Stall=0 and BusyVec=0.
- Write:
  - WrEn = RegWrite & (Rd != 0).
  - On posedge, if WrEn, the array entry at Rd takes WriteData.
  - RegWrite with Rd=0 is ignored: no array change, no busy change.
- Read, combinational:
  - If Rs1==0, ReadData1=0.
  - Else if WrEn and Rd==Rs1, ReadData1=WriteData (same-cycle bypass).
  - Otherwise ReadData1 is the array entry at Rs1.
  - ReadData2 follows the same rules using Rs2.
  - A write is therefore visible to a read in the same cycle (zero latency).
- Effective busy, combinational: effbusy[i] = busy[i] & ~(WrEn & Rd==i).
  - A register whose writeback lands this cycle counts as not busy.
  - Bit 0 is always 0.
- Stall:
  - Stall = IssueValid & ((IssueUsesRs1 & effbusy[Rs1]) | (IssueUsesRs2 & effbusy[Rs2]) | (IssueWrites & effbusy[IssueRd])).
  - The last term is the WAW check.
  - Stall is forced to 0 when Flush=1.
- Issue: Fire = IssueValid & ~Stall & ~Flush & IssueWrites & (IssueRd != 0).
- Scoreboard update on posedge, in priority order:
  1. Flush: all busy bits go to 0. A concurrent Fire is not recorded, and a concurrent write still updates the array.
  2. Otherwise busy[Rd] is cleared if WrEn.
  3. Then busy[IssueRd] is set if Fire. If Rd==IssueRd in the same cycle, the set wins and the bit ends at 1.
- Writebacks arriving after a Flush still update the array; they are not checked against the scoreboard.
- BusyVec is the registered busy vector, not the effective one.
- All Rs, Rd and IssueRd values are in range by construction; no wrap handling is needed.

Test Plan:
- Reset with INIT_INDEX=1; Rs1=5, Rs2=31 -> ReadData1=5, ReadData2=31, BusyVec=0, Stall=0. Assert reset mid-run after writes -> values return to the index values immediately.
- RegWrite=1, Rd=7, WriteData=0xDEAD with Rs1=7 in the same cycle -> ReadData1=0xDEAD combinationally; next cycle the array holds 0xDEAD. Rd=0, WriteData=0x55 -> register 0 still reads 0.
- Issue IssueRd=3, IssueWrites=1 -> BusyVec[3]=1. Next cycle issue with Rs1=3, IssueUsesRs1=1 -> Stall=1. Writeback Rd=3, WriteData=0x99 that cycle -> Stall=0, ReadData1=0x99.
- WAW: BusyVec[4]=1, then issue IssueRd=4 -> Stall=1. Same cycle: writeback to 4 plus issue to 4 -> Stall=0 and BusyVec[4] stays 1.
- Flush with BusyVec=0x18 and IssueValid=1 -> Stall=0, BusyVec=0 next cycle. A later RegWrite to Rd=3 still updates the array.
- IssueUsesRs2=0 with Rs2 busy -> Stall=0. IssueWrites=1, IssueRd=0 -> BusyVec unchanged.
